// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational ALU between two requesters. Round-robin arbitration
// picks a requester each cycle. The granted requester's command and operands
// drive the ALU. The ALU result and flags are captured into a single-entry
// response register, which has its own valid/ready handshake.
//
// Ports
//   clk, reset                      rising-edge clock, synchronous active-high reset
//   req{0,1}_valid/_ready           per-requester handshake
//   req{0,1}_op/_a/_b               ALU command (3 bits) and operands
//   alu_command/_operandA/_operandB outputs to the shared ALU
//   alu_result/_zero/_carryout/_overflow  ALU outputs, sampled in the same cycle
//   rsp_valid/rsp_ready             response handshake
//   rsp_id                          requester that owns the held response
//   rsp_result/_zero/_carryout/_overflow  captured ALU outputs
//   ops_done                        count of accepted operations; wraps
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [2:0]           req0_op,
  input  logic [WIDTH-1:0]     req0_a,
  input  logic [WIDTH-1:0]     req0_b,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [2:0]           req1_op,
  input  logic [WIDTH-1:0]     req1_a,
  input  logic [WIDTH-1:0]     req1_b,
  output logic [2:0]           alu_command,
  output logic [WIDTH-1:0]     alu_operandA,
  output logic [WIDTH-1:0]     alu_operandB,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic                 alu_zero,
  input  logic                 alu_carryout,
  input  logic                 alu_overflow,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [WIDTH-1:0]     rsp_result,
  output logic                 rsp_zero,
  output logic                 rsp_carryout,
  output logic                 rsp_overflow,
  output logic [CNT_WIDTH-1:0] ops_done
);

  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]     rsp_result_q, rsp_result_d;
  logic                 rsp_zero_q, rsp_zero_d;
  logic                 rsp_carryout_q, rsp_carryout_d;
  logic                 rsp_overflow_q, rsp_overflow_d;
  logic [CNT_WIDTH-1:0] ops_done_q, ops_done_d;
  logic                 last_grant_q, last_grant_d;

  logic grant_valid_s;
  logic grant_id_s;
  logic can_accept_s;
  logic accept_s;

  // Round-robin grant: on a tie, the requester that did not win last time is chosen.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_id_s    = 1'b0;
    case ({req1_valid, req0_valid})
      2'b01: begin
        grant_valid_s = 1'b1;
        grant_id_s    = 1'b0;
      end
      2'b10: begin
        grant_valid_s = 1'b1;
        grant_id_s    = 1'b1;
      end
      2'b11: begin
        grant_valid_s = 1'b1;
        grant_id_s    = ~last_grant_q;
      end
      default: begin
        grant_valid_s = 1'b0;
        grant_id_s    = 1'b0;
      end
    endcase
  end

  // The slot can take a new result when it is empty or is being drained this cycle.
  assign can_accept_s = ~rsp_valid_q | rsp_ready;
  assign accept_s     = can_accept_s & grant_valid_s;
  assign req0_ready   = accept_s & ~grant_id_s;
  assign req1_ready   = accept_s & grant_id_s;

  // ALU input mux: use the granted requester's operation, or all zeros when idle.
  always_comb begin
    alu_command  = 3'd0;
    alu_operandA = {WIDTH{1'b0}};
    alu_operandB = {WIDTH{1'b0}};
    if (grant_valid_s) begin
      if (grant_id_s) begin
        alu_command  = req1_op;
        alu_operandA = req1_a;
        alu_operandB = req1_b;
      end else begin
        alu_command  = req0_op;
        alu_operandA = req0_a;
        alu_operandB = req0_b;
      end
    end else begin
      alu_command  = 3'd0;
      alu_operandA = {WIDTH{1'b0}};
      alu_operandB = {WIDTH{1'b0}};
    end
  end

  // Response slot next state: load on accept, clear valid on drain, otherwise hold.
  always_comb begin
    rsp_valid_d    = rsp_valid_q;
    rsp_id_d       = rsp_id_q;
    rsp_result_d   = rsp_result_q;
    rsp_zero_d     = rsp_zero_q;
    rsp_carryout_d = rsp_carryout_q;
    rsp_overflow_d = rsp_overflow_q;
    ops_done_d     = ops_done_q;
    last_grant_d   = last_grant_q;
    if (accept_s) begin
      rsp_valid_d    = 1'b1;
      rsp_id_d       = grant_id_s;
      rsp_result_d   = alu_result;
      rsp_zero_d     = alu_zero;
      rsp_carryout_d = alu_carryout;
      rsp_overflow_d = alu_overflow;
      ops_done_d     = ops_done_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      last_grant_d   = grant_id_s;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
  end

  // State registers. Reset sets last_grant to 1 so that requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= 1'b0;
      rsp_result_q   <= {WIDTH{1'b0}};
      rsp_zero_q     <= 1'b0;
      rsp_carryout_q <= 1'b0;
      rsp_overflow_q <= 1'b0;
      ops_done_q     <= {CNT_WIDTH{1'b0}};
      last_grant_q   <= 1'b1;
    end else begin
      rsp_valid_q    <= rsp_valid_d;
      rsp_id_q       <= rsp_id_d;
      rsp_result_q   <= rsp_result_d;
      rsp_zero_q     <= rsp_zero_d;
      rsp_carryout_q <= rsp_carryout_d;
      rsp_overflow_q <= rsp_overflow_d;
      ops_done_q     <= ops_done_d;
      last_grant_q   <= last_grant_d;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_carryout = rsp_carryout_q;
  assign rsp_overflow = rsp_overflow_q;
  assign ops_done     = ops_done_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Testbench for alu_arbiter. It applies directed vectors and compares the
// outputs every cycle against a behavioural model, plus a set of literal
// expectations. A second instance with CNT_WIDTH=4 gets the same stimulus, so
// the wrap of the operation counter can be checked.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid, req1_valid, rsp_ready;
  logic [2:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;

  logic        req0_ready, req1_ready;
  logic [2:0]  alu_command;
  logic [31:0] alu_operandA, alu_operandB, alu_result;
  logic        alu_zero, alu_carryout, alu_overflow;
  logic        rsp_valid, rsp_id, rsp_zero, rsp_carryout, rsp_overflow;
  logic [31:0] rsp_result;
  logic [15:0] ops_done;

  logic        s_req0_ready, s_req1_ready;
  logic [2:0]  s_alu_command;
  logic [31:0] s_alu_operandA, s_alu_operandB, s_alu_result;
  logic        s_alu_zero, s_alu_carryout, s_alu_overflow;
  logic        s_rsp_valid, s_rsp_id, s_rsp_zero, s_rsp_carryout, s_rsp_overflow;
  logic [31:0] s_rsp_result;
  logic [3:0]  s_ops_done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference ALU32bit. It returns {carryout, overflow, zero, result}.
  function automatic logic [34:0] alu_ref(input logic [2:0] cmd, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [32:0] sum;
    logic [31:0] r;
    logic        c, v;
    c = 1'b0;
    v = 1'b0;
    case (cmd)
      3'd0: begin
        sum = {1'b0, a} + {1'b0, b};
        r = sum[31:0];
        c = sum[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'd1, 3'd3: begin
        sum = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = sum[31:0];
        c = sum[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
        if (cmd == 3'd3) r = {31'd0, r[31] ^ v};
      end
      3'd2: r = a ^ b;
      3'd4: r = a & b;
      3'd5: r = ~(a & b);
      3'd6: r = ~(a | b);
      default: r = a | b;
    endcase
    return {c, v, (r == 32'd0), r};
  endfunction

  assign {alu_carryout, alu_overflow, alu_zero, alu_result} =
         alu_ref(alu_command, alu_operandA, alu_operandB);
  assign {s_alu_carryout, s_alu_overflow, s_alu_zero, s_alu_result} =
         alu_ref(s_alu_command, s_alu_operandA, s_alu_operandB);

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_command(alu_command), .alu_operandA(alu_operandA), .alu_operandB(alu_operandB),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_carryout(alu_carryout),
    .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_carryout(rsp_carryout),
    .rsp_overflow(rsp_overflow), .ops_done(ops_done)
  );

  alu_arbiter #(.WIDTH(32), .CNT_WIDTH(4)) dut_small (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(s_req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(s_req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_command(s_alu_command), .alu_operandA(s_alu_operandA),
    .alu_operandB(s_alu_operandB),
    .alu_result(s_alu_result), .alu_zero(s_alu_zero), .alu_carryout(s_alu_carryout),
    .alu_overflow(s_alu_overflow),
    .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(s_rsp_id),
    .rsp_result(s_rsp_result), .rsp_zero(s_rsp_zero), .rsp_carryout(s_rsp_carryout),
    .rsp_overflow(s_rsp_overflow), .ops_done(s_ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  // ---------------- behavioural model ----------------
  bit          m_ok = 1'b0;
  bit          m_valid;
  int          m_id;
  logic [31:0] m_res;
  logic        m_z, m_c, m_v;
  int          m_cnt;
  int          m_last;

  // Returns the winning requester, or -1 when no requester is valid.
  function automatic int pick(input logic v0, input logic v1, input int last);
    if (v0 && v1) return (last == 0) ? 1 : 0;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  // Update the model at each rising edge, using the inputs held during the cycle.
  always @(posedge clk) begin
    int g;
    logic [34:0] r;
    if (reset) begin
      m_valid = 1'b0; m_id = 0; m_res = 32'd0;
      m_z = 1'b0; m_c = 1'b0; m_v = 1'b0; m_cnt = 0; m_last = 1;
    end else begin
      g = pick(req0_valid, req1_valid, m_last);
      if (g >= 0 && (!m_valid || rsp_ready)) begin
        r = (g == 0) ? alu_ref(req0_op, req0_a, req0_b) : alu_ref(req1_op, req1_a, req1_b);
        {m_c, m_v, m_z, m_res} = r;
        m_valid = 1'b1;
        m_id = g;
        m_last = g;
        m_cnt = m_cnt + 1;
      end else if (m_valid && rsp_ready) begin
        m_valid = 1'b0;
      end
    end
    m_ok = 1'b1;
  end

  // Compare the DUT against the model on every falling edge.
  always @(negedge clk) begin
    int g;
    bit acc;
    if (m_ok) begin
      g   = pick(req0_valid, req1_valid, m_last);
      acc = (g >= 0) && (!m_valid || rsp_ready);
      chk("rsp_valid", rsp_valid, m_valid);
      chk("rsp_id", rsp_id, m_id[0]);
      chk("rsp_result", rsp_result, m_res);
      chk("rsp_zero", rsp_zero, m_z);
      chk("rsp_carryout", rsp_carryout, m_c);
      chk("rsp_overflow", rsp_overflow, m_v);
      chk("ops_done", ops_done, m_cnt % 65536);
      chk("ops_done_w4", s_ops_done, m_cnt % 16);
      chk("s_rsp_result", s_rsp_result, m_res);
      chk("req0_ready", req0_ready, acc && g == 0);
      chk("req1_ready", req1_ready, acc && g == 1);
      chk("alu_command", alu_command, (g == 0) ? req0_op : (g == 1) ? req1_op : 3'd0);
      chk("alu_operandA", alu_operandA, (g == 0) ? req0_a : (g == 1) ? req1_a : 32'd0);
      chk("alu_operandB", alu_operandB, (g == 0) ? req0_b : (g == 1) ? req1_b : 32'd0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic v0, input logic [2:0] o0, input logic [31:0] a0,
                       input logic [31:0] b0, input logic v1, input logic [2:0] o1,
                       input logic [31:0] a1, input logic [31:0] b1,
                       input logic rr, input logic rst);
    req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
    rsp_ready = rr; reset = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rst);
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1, rst);
  endtask

  initial begin
    logic [2:0]  ops5 [4];
    logic [31:0] exp5 [4];
    ops5[0] = 3'd2; ops5[1] = 3'd4; ops5[2] = 3'd5; ops5[3] = 3'd6;
    exp5[0] = 32'h95511559; exp5[1] = 32'h02244220;
    exp5[2] = 32'hFDDBBDDF; exp5[3] = 32'h688AA886;

    idle(1'b1);
    idle(1'b1);
    chk("reset_valid", rsp_valid, 1'b0);
    chk("reset_ops", ops_done, 16'd0);
    chk("reset_result", rsp_result, 32'd0);
    idle(1'b0);

    // Single ADD from requester 0, which overflows.
    drive(1'b1, 3'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("t1_valid", rsp_valid, 1'b1);
    chk("t1_id", rsp_id, 1'b0);
    chk("t1_result", rsp_result, 32'hFFFFFFFE);
    chk("t1_ovf", rsp_overflow, 1'b1);
    chk("t1_carry", rsp_carryout, 1'b0);
    chk("t1_zero", rsp_zero, 1'b0);
    chk("t1_ops", ops_done, 16'd1);
    idle(1'b0);

    // Both requesters valid every cycle, starting right after reset.
    idle(1'b1);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 3'd1, 32'h12345678, 32'h12345678,
            1'b1, 3'd3, 32'h12345678, 32'h7FFFFFFF, 1'b1, 1'b0);
      chk("t2_id", rsp_id, k[0]);
      chk("t2_result", rsp_result, k[0] ? 32'd1 : 32'd0);
      chk("t2_zero", rsp_zero, !k[0]);
    end

    // Backpressure for 3 cycles, then release.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 3'd1, 32'h12345678, 32'h12345678,
            1'b1, 3'd3, 32'h12345678, 32'h7FFFFFFF, 1'b0, 1'b0);
      chk("t3_r0_stall", req0_ready, 1'b0);
      chk("t3_r1_stall", req1_ready, 1'b0);
      chk("t3_ops_hold", ops_done, 16'd4);
    end
    rsp_ready = 1'b1;
    #1;
    chk("t3_r0_release", req0_ready, 1'b1);
    chk("t3_r1_release", req1_ready, 1'b0);
    @(posedge clk);
    #1;
    chk("t3_ops_after", ops_done, 16'd5);
    chk("t3_id_after", rsp_id, 1'b0);

    // Reset while a response is held and requests are pending.
    drive(1'b1, 3'd0, 32'd3, 32'd4, 1'b1, 3'd7, 32'd1, 32'd2, 1'b0, 1'b1);
    chk("t4_valid", rsp_valid, 1'b0);
    chk("t4_ops", ops_done, 16'd0);
    drive(1'b1, 3'd0, 32'd3, 32'd4, 1'b1, 3'd7, 32'd1, 32'd2, 1'b1, 1'b0);
    chk("t4_first_tie", rsp_id, 1'b0);
    chk("t4_result", rsp_result, 32'd7);

    // Requester 1 streams four logic ops.
    idle(1'b1);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, ops5[k], 32'h87654321, 32'h12345678,
            1'b1, 1'b0);
      chk("t5_result", rsp_result, exp5[k]);
      chk("t5_id", rsp_id, 1'b1);
    end
    chk("t5_ops", ops_done, 16'd4);
    idle(1'b0);

    // Seventeen ops wrap the 4-bit counter. The last op is a NAND that gives zero.
    idle(1'b1);
    for (int k = 0; k < 16; k++)
      drive(1'b1, 3'd7, k, 32'h10, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    drive(1'b1, 3'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("t6_wrap", s_ops_done, 4'd1);
    chk("t6_ops", ops_done, 16'd17);
    chk("t6_nand", rsp_result, 32'd0);
    chk("t6_nand_zero", rsp_zero, 1'b1);
    idle(1'b0);
    idle(1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
